// File: rtl/oclib_uart_csr_responder.sv
// UART-side CSR responder: decodes ASCII peek/poke commands arriving on the
// RX byte stream, performs one req/ack CSR access per command and streams
// the reply bytes back toward the UART TX path.
module oclib_uart_csr_responder #(
  parameter int InterByteTimeout = 1_000_000,
  parameter int CsrTimeout       = 1024,
  parameter int CsrDataWidth     = 8
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [7:0]              rxData,
  input  logic                    rxValid,
  output logic                    rxReady,
  output logic [7:0]              txData,
  output logic                    txValid,
  input  logic                    txReady,
  output logic [7:0]              csrAddr,
  output logic [CsrDataWidth-1:0] csrWdata,
  output logic                    csrWrite,
  output logic                    csrReq,
  input  logic                    csrAck,
  input  logic [CsrDataWidth-1:0] csrRdata,
  output logic [1:0]              error
);

  // Reply bytes carry CSR data directly, so the data path must be one byte.
  if (CsrDataWidth != 8) begin : g_bad_width
    $error("oclib_uart_csr_responder: CsrDataWidth must be 8");
  end

  localparam int IbCntW  = $clog2(InterByteTimeout + 1);
  localparam int CsrCntW = $clog2(CsrTimeout + 1);

  // Last count value before the timer expires; expiry is detected one cycle
  // early so the abort lands exactly Timeout cycles after the last event.
  localparam logic [IbCntW-1:0]  IbLast  = IbCntW'(InterByteTimeout - 1);
  localparam logic [CsrCntW-1:0] CsrLast = CsrCntW'(CsrTimeout - 1);

  localparam logic [7:0] CmdPing  = 8'h50;  // 'P'
  localparam logic [7:0] CmdRead  = 8'h52;  // 'R'
  localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] ChLf     = 8'h0A;
  localparam logic [7:0] ChCr     = 8'h0D;
  localparam logic [7:0] RspPong  = 8'h70;  // 'p'
  localparam logic [7:0] RspOk    = 8'h4B;  // 'K'
  localparam logic [7:0] RspWhat  = 8'h3F;  // '?'
  localparam logic [7:0] RspFail  = 8'h21;  // '!'

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    CSR,
    SEND1,
    SEND2
  } state_e;

  state_e                  state_q,     state_d;
  logic                    rx_ready_q,  rx_ready_d;
  logic [7:0]              tx_data_q,   tx_data_d;
  logic                    tx_valid_q,  tx_valid_d;
  logic                    pending_q,   pending_d;
  logic [7:0]              csr_addr_q,  csr_addr_d;
  logic [CsrDataWidth-1:0] csr_wdata_q, csr_wdata_d;
  logic                    csr_write_q, csr_write_d;
  logic                    csr_req_q,   csr_req_d;
  logic [1:0]              error_q,     error_d;
  logic [IbCntW-1:0]       ib_cnt_q,    ib_cnt_d;
  logic [CsrCntW-1:0]      csr_cnt_q,   csr_cnt_d;

  logic rx_accept;
  assign rx_accept = rxValid & rx_ready_q;

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d     = state_q;
    rx_ready_d  = rx_ready_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    pending_d   = pending_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_write_d = csr_write_q;
    csr_req_d   = csr_req_q;
    error_d     = 2'b00;
    ib_cnt_d    = ib_cnt_q;
    csr_cnt_d   = csr_cnt_q;

    unique case (state_q)
      IDLE: begin
        rx_ready_d = 1'b1;
        if (rx_accept) begin
          case (rxData)
            CmdRead, CmdWrite: begin
              csr_write_d = (rxData == CmdWrite);
              ib_cnt_d    = '0;
              state_d     = GET_ADDR;
            end
            ChLf, ChCr: begin
              // Line endings from a terminal are swallowed silently.
            end
            default: begin
              tx_data_d  = (rxData == CmdPing) ? RspPong : RspWhat;
              tx_valid_d = 1'b1;
              pending_d  = 1'b0;
              rx_ready_d = 1'b0;
              state_d    = SEND1;
            end
          endcase
        end
      end

      GET_ADDR, GET_DATA: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (rx_accept) begin
          ib_cnt_d = '0;
          if (state_q == GET_ADDR) begin
            csr_addr_d = rxData;
          end else begin
            csr_wdata_d = rxData;
          end
          if (state_q == GET_ADDR && csr_write_q) begin
            state_d = GET_DATA;
          end else begin
            rx_ready_d = 1'b0;
            csr_req_d  = 1'b1;
            csr_cnt_d  = '0;
            state_d    = CSR;
          end
        end else if (ib_cnt_q == IbLast) begin
          error_d[0] = 1'b1;
          state_d    = IDLE;
        end else begin
          ib_cnt_d = ib_cnt_q + 1'b1;
        end
      end

      CSR: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (csrAck) begin
          csr_req_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = csr_write_q ? RspOk : csrRdata;
          pending_d  = ~csr_write_q;
          state_d    = SEND1;
        end else if (csr_cnt_q == CsrLast) begin
          csr_req_d  = 1'b0;
          error_d[1] = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = RspFail;
          pending_d  = 1'b0;
          state_d    = SEND1;
        end else begin
          csr_cnt_d = csr_cnt_q + 1'b1;
        end
      end

      SEND1: begin
        if (txReady) begin
          if (pending_q) begin
            tx_data_d = RspOk;
            pending_d = 1'b0;
            state_d   = SEND2;
          end else begin
            tx_valid_d = 1'b0;
            rx_ready_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      SEND2: begin
        if (txReady) begin
          tx_valid_d = 1'b0;
          rx_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; every flop clears on reset, including
  // mid-command and mid-access.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      pending_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_write_q <= 1'b0;
      csr_req_q   <= 1'b0;
      error_q     <= '0;
      ib_cnt_q    <= '0;
      csr_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values.
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      pending_q   <= pending_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_write_q <= csr_write_d;
      csr_req_q   <= csr_req_d;
      error_q     <= error_d;
      ib_cnt_q    <= ib_cnt_d;
      csr_cnt_q   <= csr_cnt_d;
    end
  end

  assign rxReady  = rx_ready_q;
  assign txData   = tx_data_q;
  assign txValid  = tx_valid_q;
  assign csrAddr  = csr_addr_q;
  assign csrWdata = csr_wdata_q;
  assign csrWrite = csr_write_q;
  assign csrReq   = csr_req_q;
  assign error    = error_q;

endmodule

// File: tb/tb_oclib_uart_csr_responder.sv
// Self-checking bench for oclib_uart_csr_responder: directed corner cases
// plus randomized command traffic scored against a byte-level reply model
// and a behavioural CSR register file.
module tb_oclib_uart_csr_responder;

  localparam int IB_TO  = 100;
  localparam int CSR_TO = 16;

  localparam logic [7:0] C_P = 8'h50;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_W = 8'h57;

  logic       clock;
  logic       resetN;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic [7:0] csrAddr;
  logic [7:0] csrWdata;
  logic       csrWrite;
  logic       csrReq;
  logic       csrAck;
  logic [7:0] csrRdata;
  logic [1:0] error;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] regs [256];
  logic [7:0] exp_q [$];

  oclib_uart_csr_responder #(
    .InterByteTimeout(IB_TO),
    .CsrTimeout      (CSR_TO),
    .CsrDataWidth    (8)
  ) dut (
    .clock   (clock),
    .resetN  (resetN),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady),
    .csrAddr (csrAddr),
    .csrWdata(csrWdata),
    .csrWrite(csrWrite),
    .csrReq  (csrReq),
    .csrAck  (csrAck),
    .csrRdata(csrRdata),
    .error   (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reply model: what the far end should say for a finished command.
  function automatic void model_reply(input logic [7:0] cmd, input logic [7:0] addr,
                                      input logic [7:0] wdata, input logic acked);
    if (cmd == 8'h0A || cmd == 8'h0D) begin
      return;
    end else if (cmd == C_P) begin
      exp_q.push_back(8'h70);
    end else if (cmd == C_R || cmd == C_W) begin
      if (!acked) begin
        exp_q.push_back(8'h21);
      end else if (cmd == C_R) begin
        exp_q.push_back(regs[addr]);
        exp_q.push_back(8'h4B);
      end else begin
        regs[addr] = wdata;
        exp_q.push_back(8'h4B);
      end
    end else begin
      exp_q.push_back(8'h3F);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) step();
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && n < 64) begin
      step();
      n++;
    end
    check("rx_ready_wait", rxReady, 1);
    step();
    rxValid = 1'b0;
    rxData  = 8'($urandom);
  endtask

  // Plays the CSR slave; entered on the sample right after the final command byte.
  task automatic csr_phase(input int dly, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           output logic acked);
    int lim;
    acked = (dly <= CSR_TO);
    lim   = acked ? dly : CSR_TO;
    check("csr_write", csrWrite, wr);
    check("csr_addr", csrAddr, addr);
    if (wr) check("csr_wdata", csrWdata, wdata);
    for (int k = 0; k < lim; k++) begin
      check("csr_req_high", csrReq, 1);
      check("csr_rx_blocked", rxReady, 0);
      if (acked && k == lim - 1) begin
        csrAck   = 1'b1;
        csrRdata = rdata;
      end
      step();
      csrAck   = 1'b0;
      csrRdata = 8'($urandom);
    end
    check("csr_req_drop", csrReq, 0);
    check("csr_err", error, acked ? 2'b00 : 2'b10);
    check("csr_reply_valid", txValid, 1);
  endtask

  // Drains the expected reply bytes with random TX back-pressure.
  task automatic collect(input int stall_pct);
    int         guard = 0;
    logic       pend  = 1'b0;
    logic [7:0] held  = 8'h00;
    while (exp_q.size() > 0 && guard < 500) begin
      txReady = ($urandom_range(99) >= stall_pct);
      check("rx_backpressure", rxReady, 0);
      if (pend) begin
        check("tx_hold_valid", txValid, 1);
        check("tx_hold_data", txData, held);
      end
      pend = 1'b0;
      if (txValid) begin
        if (txReady) begin
          check("tx_byte", txData, exp_q.pop_front());
        end else begin
          pend = 1'b1;
          held = txData;
        end
      end
      step();
      guard++;
      check("err_quiet", error, 0);
    end
    txReady = 1'b0;
    check("tx_drained", exp_q.size(), 0);
  endtask

  // Quiet window; stray csrAck outside an access must be ignored.
  task automatic idle_check(input int n);
    repeat (n) begin
      csrAck   = 1'($urandom_range(1));
      csrRdata = 8'($urandom);
      check("idle_tx", txValid, 0);
      check("idle_req", csrReq, 0);
      check("idle_err", error, 0);
      step();
    end
    csrAck = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] wdata,
                         input int ack_dly, input int stall_pct, input int gap);
    logic acked;
    acked = 1'b1;
    send_byte(cmd, gap);
    if (cmd == C_R || cmd == C_W) begin
      send_byte(addr, gap);
      if (cmd == C_W) send_byte(wdata, gap);
      csr_phase(ack_dly, cmd == C_W, addr, wdata, regs[addr], acked);
    end
    model_reply(cmd, addr, wdata, acked);
    collect(stall_pct);
    idle_check(2);
  endtask

  initial begin
    logic       acked;
    logic [7:0] cmd;
    int         kind;
    int         dly;

    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    resetN = 1'b0; rxValid = 1'b0; rxData = 8'h00; txReady = 1'b0;
    csrAck = 1'b0; csrRdata = 8'h00;

    // Reset values while held in reset and right after release.
    #12;
    check("rst_rx_ready", rxReady, 0);
    check("rst_tx_valid", txValid, 0);
    check("rst_tx_data", txData, 0);
    check("rst_csr_req", csrReq, 0);
    check("rst_csr_write", csrWrite, 0);
    check("rst_csr_addr", csrAddr, 0);
    check("rst_csr_wdata", csrWdata, 0);
    check("rst_error", error, 0);
    #10 resetN = 1'b1;
    check("rel_rx_ready", rxReady, 0);
    step();
    check("idle_rx_ready", rxReady, 1);

    // Ping with TX always ready: one-cycle pong, back to IDLE.
    txReady = 1'b1;
    send_byte(C_P, 0);
    check("ping_valid", txValid, 1);
    check("ping_data", txData, 8'h70);
    step();
    check("ping_one_cycle", txValid, 0);
    check("ping_idle_ready", rxReady, 1);
    txReady = 1'b0;

    // Write with ack three cycles after the request.
    run_cmd(C_W, 8'h12, 8'hA5, 3, 0, 0);
    check("model_wr", regs[8'h12], 8'hA5);

    // Read with TX stalled for 10 cycles.
    regs[8'h34] = 8'h5C;
    send_byte(C_R, 0);
    send_byte(8'h34, 0);
    csr_phase(2, 1'b0, 8'h34, 8'h00, 8'h5C, acked);
    repeat (10) begin
      check("rd_stall_valid", txValid, 1);
      check("rd_stall_data", txData, 8'h5C);
      check("rd_stall_rx", rxReady, 0);
      step();
    end
    model_reply(C_R, 8'h34, 8'h00, acked);
    collect(0);
    idle_check(2);

    // Inter-byte timeout after the address byte.
    send_byte(C_W, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < IB_TO; i++) begin
      check("ib_wait_err", error, 0);
      check("ib_wait_tx", txValid, 0);
      step();
    end
    check("ib_timeout_pulse", error, 2'b01);
    step();
    check("ib_pulse_end", error, 0);
    idle_check(3);
    run_cmd(C_P, 8'h00, 8'h00, 1, 0, 0);

    // Data byte on the very expiry cycle wins over the timeout.
    send_byte(C_W, 0);
    send_byte(8'h02, 0);
    repeat (IB_TO - 1) step();
    send_byte(8'h3C, 0);
    check("ib_race_err", error, 0);
    csr_phase(1, 1'b1, 8'h02, 8'h3C, 8'h00, acked);
    model_reply(C_W, 8'h02, 8'h3C, acked);
    collect(0);
    idle_check(2);

    // CSR timeout, then ack exactly on the expiry cycle.
    run_cmd(C_R, 8'h07, 8'h00, CSR_TO + 5, 30, 0);
    run_cmd(C_W, 8'h08, 8'h99, CSR_TO, 30, 0);
    run_cmd(C_R, 8'h08, 8'h00, CSR_TO + 1, 0, 0);
    run_cmd(C_R, 8'h08, 8'h00, 1, 50, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(9);
      if (kind < 2)      cmd = C_P;
      else if (kind < 5) cmd = C_R;
      else if (kind < 8) cmd = C_W;
      else if (kind == 9) cmd = ($urandom_range(1) == 1) ? 8'h0A : 8'h0D;
      else begin
        cmd = 8'($urandom);
        while (cmd == C_P || cmd == C_R || cmd == C_W || cmd == 8'h0A || cmd == 8'h0D)
          cmd = 8'($urandom);
      end
      dly = ($urandom_range(9) == 0) ? CSR_TO + 1 + $urandom_range(3) : $urandom_range(1, CSR_TO);
      run_cmd(cmd, 8'($urandom_range(15)), 8'($urandom), dly, $urandom_range(60), $urandom_range(3));
    end

    // Unknown byte, swallowed CR, then asynchronous resets mid-reply and mid-access.
    run_cmd(8'h41, 8'h00, 8'h00, 1, 0, 0);
    send_byte(8'h0D, 0);
    idle_check(4);

    send_byte(C_P, 0);
    check("pre_rst_tx", txValid, 1);
    #2 resetN = 1'b0;
    #1;
    check("arst_tx_valid", txValid, 0);
    check("arst_tx_data", txData, 0);
    #3 resetN = 1'b1;
    step();

    send_byte(C_R, 0);
    send_byte(8'h22, 0);
    check("pre_rst_req", csrReq, 1);
    #2 resetN = 1'b0;
    #1;
    check("arst_csr_req", csrReq, 0);
    check("arst_csr_addr", csrAddr, 0);
    check("arst_rx_ready", rxReady, 0);
    check("arst_tx_valid2", txValid, 0);
    #3 resetN = 1'b1;
    step();
    check("post_rst_ready", rxReady, 1);
    run_cmd(C_P, 8'h00, 8'h00, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
